// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage int32 to IEEE-754 single converter, round-nearest-even.
// Stages: sign/magnitude, normalize, round/pack; one result per cycle.
package itof_pkg;
    typedef struct packed {
        logic        v;
        logic        s;
        logic        z;
        logic [31:0] m;
    } s1_t;

    typedef struct packed {
        logic        v;
        logic        s;
        logic        z;
        logic [7:0]  e;
        logic [30:0] f;
    } s2_t;
endpackage

module itof_pipe
    import itof_pkg::*;
#(
    parameter bit UNSIGNED_IN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    logic        adv;
    s1_t         s1_q;
    s1_t         s1_d;
    s2_t         s2_q;
    s2_t         s2_d;
    logic [4:0]  lz;
    logic [30:0] n;
    logic        rnd;
    logic [23:0] fr;
    logic [7:0]  e3;
    logic [31:0] y_d;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        s1_d   = '0;
        s1_d.v = in_valid;
        s1_d.s = x[31] & ~UNSIGNED_IN;
        s1_d.z = (x == 32'd0);
        s1_d.m = s1_d.s ? (~x + 32'd1) : x;
    end

    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (s1_q.m[i]) lz = 5'(31 - i);
        end
    end

    // Leading one is implied after normalization, so only keep bits below it.
    assign n = 31'(s1_q.m << lz);

    always_comb begin
        s2_d   = '0;
        s2_d.v = s1_q.v;
        s2_d.s = s1_q.s;
        s2_d.z = s1_q.z;
        s2_d.e = 8'd158 - {3'd0, lz};
        s2_d.f = n;
    end

    // Carry out of the 23-bit fraction means the mantissa rolled to 2.0.
    assign rnd = s2_q.f[7] & ((|s2_q.f[6:0]) | s2_q.f[8]);
    assign fr  = {1'b0, s2_q.f[30:8]} + {23'd0, rnd};
    assign e3  = s2_q.e + {7'd0, fr[23]};
    assign y_d = s2_q.z ? 32'd0 : {s2_q.s, e3, fr[22:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            out_valid <= 1'b0;
            y         <= 32'd0;
        end else if (adv) begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            out_valid <= s2_q.v;
            y         <= y_d;
        end
    end

endmodule
